// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority controller.
//  - irq_state_t : request sequencing states (IDLE / REQ / SERVICE)
//  - CFG_*       : cfg_sel encodings for the configuration write port
//  - VEC_*       : default handler vector base and per-source byte stride
//  - vec_addr()  : handler address for a given source index
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] CFG_ENABLE = 2'd0;
    localparam logic [1:0] CFG_EDGE   = 2'd1;
    localparam logic [1:0] CFG_SWSET  = 2'd2;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0018;
    localparam int          VEC_STRIDE_DEFAULT = 4;

    // Full 32-bit product so the offset never wraps for legal source counts.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [3:0]  id);
        return base + ({28'd0, id} * stride);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority find-first-set encoder.
//  req  : request vector, bit 0 has the highest priority
//  idx  : index of the lowest set bit (0 when nothing is set)
//  vld  : at least one request bit is set
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [3:0]   idx,
    output logic         vld
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = 4'd0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Interrupt controller for a single CPU IRQ line.
// Masks and latches N_SRC peripheral sources, selects the lowest-index eligible
// source, presents it to the CPU as EX_irq + INT_Vector, and tracks one
// in-service interrupt until end-of-interrupt. No nesting.
// Ports:
//  clk, Rst            clock, synchronous active-high reset
//  irq_src             raw source lines (synchronous to clk)
//  cfg_we/sel/wdata    config write: enable mask, edge-mode select, software set
//  irq_ack, irq_eoi    CPU acknowledge / handler end-of-interrupt pulses
//  EX_irq, INT_Vector  request and handler address to the CPU
//  irq_id              latched source index
//  in_service          high from ack until eoi
//  pending             current pending bits (readback)
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [N_SRC-1:0] cfg_wdata,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic             EX_irq,
    output logic [31:0]      INT_Vector,
    output logic [3:0]       irq_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    irq_state_t       state;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] src_hist;
    logic [N_SRC-1:0] pend_edge;

    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] sw_set;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] eligible;
    logic [3:0]       win_idx;
    logic             win_vld;
    logic             ack_fire;

    assign ack_fire = (state == ST_REQ) && irq_ack;

    // Edge bits come from the latched register; level bits follow the line live.
    assign pending  = (edge_mode & pend_edge) | (~edge_mode & irq_src);
    assign eligible = pending & enable;
    assign edge_set = irq_src & ~src_hist & edge_mode;
    assign sw_set   = (cfg_we && cfg_sel == CFG_SWSET) ? cfg_wdata : '0;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_fire && (irq_id == 4'(i));
        end
    end

    irq_prio_enc #(.N(N_SRC)) u_enc (
        .req (eligible),
        .idx (win_idx),
        .vld (win_vld)
    );

    // Configuration, edge history and latched pending. A new set in the same
    // cycle as an ack clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (Rst) begin
            enable    <= '0;
            edge_mode <= '0;
            src_hist  <= '0;
            pend_edge <= '0;
        end else begin
            src_hist  <= irq_src;
            pend_edge <= (pend_edge & ~ack_clr) | edge_set | sw_set;
            if (cfg_we && cfg_sel == CFG_ENABLE) enable    <= cfg_wdata;
            if (cfg_we && cfg_sel == CFG_EDGE)   edge_mode <= cfg_wdata;
        end
    end

    // Request sequencing; all CPU-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            EX_irq     <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= 4'd0;
            INT_Vector <= VEC_BASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state      <= ST_REQ;
                        EX_irq     <= 1'b1;
                        irq_id     <= win_idx;
                        INT_Vector <= vec_addr(VEC_BASE, 32'(VEC_STRIDE), win_idx);
                    end
                end
                ST_REQ: begin
                    // The latched request stays up until acked; eoi has no effect here.
                    if (irq_ack) begin
                        state      <= ST_SERVICE;
                        EX_irq     <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (irq_eoi) begin
                        state      <= ST_IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    EX_irq     <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;
    import irq_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         Rst;
    logic [N-1:0] irq_src;
    logic         cfg_we;
    logic [1:0]   cfg_sel;
    logic [N-1:0] cfg_wdata;
    logic         irq_ack;
    logic         irq_eoi;
    logic         EX_irq;
    logic [31:0]  INT_Vector;
    logic [3:0]   irq_id;
    logic         in_service;
    logic [N-1:0] pending;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;

    irq_priority_ctrl #(.N_SRC(N), .VEC_BASE(32'h18), .VEC_STRIDE(4)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .irq_src    (irq_src),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .EX_irq     (EX_irq),
        .INT_Vector (INT_Vector),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [N-1:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns the number of edges until EX_irq is seen high, or -1 on timeout.
    task automatic wait_irq(input int limit, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (EX_irq !== 1'b1 && cycles < limit);
        if (EX_irq !== 1'b1) cycles = -1;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick(); tick();
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL reset_ex_irq got %b want 0", EX_irq); else n_pass++;
        n_checks++; if (INT_Vector !== 32'h18) $display("FAIL reset_vector got %h want 00000018", INT_Vector); else n_pass++;
        n_checks++; if (pending !== 8'h00) $display("FAIL reset_pending got %h want 00", pending); else n_pass++;
        n_checks++; if (in_service !== 1'b0) $display("FAIL reset_in_service got %b want 0", in_service); else n_pass++;
        n_checks++; if (irq_id !== 4'd0) $display("FAIL reset_irq_id got %0d want 0", irq_id); else n_pass++;
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_edge_basic();
        cfg_write(CFG_ENABLE, 8'hFF);
        cfg_write(CFG_EDGE, 8'h04);
        irq_src[2] = 1'b1;
        sb.push_back('{id: 4'd2, vec: 32'h20});
        tick();
        irq_src[2] = 1'b0;
        n_checks++; if (pending[2] !== 1'b1) $display("FAIL edge_pending_set got %b want 1", pending[2]); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL edge_latency_early got %b want 0", EX_irq); else n_pass++;
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL edge_latency got %0d want 1", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL edge_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL edge_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        pulse_ack();
        n_checks++; if (pending[2] !== 1'b0) $display("FAIL edge_ack_clear got %b want 0", pending[2]); else n_pass++;
        n_checks++; if (in_service !== 1'b1) $display("FAIL edge_in_service got %b want 1", in_service); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL edge_ex_after_ack got %b want 0", EX_irq); else n_pass++;
        pulse_eoi();
        n_checks++; if (in_service !== 1'b0) $display("FAIL edge_eoi got %b want 0", in_service); else n_pass++;
        tick(); tick();
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL edge_quiet_after_eoi got %b want 0", EX_irq); else n_pass++;
    endtask

    task automatic test_priority();
        cfg_write(CFG_EDGE, 8'h00);
        irq_src[5] = 1'b1;
        irq_src[1] = 1'b1;
        sb.push_back('{id: 4'd1, vec: 32'h1C});
        sb.push_back('{id: 4'd5, vec: 32'h2C});
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL prio_latency got %0d want 1", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL prio_first_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL prio_first_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        pulse_ack();
        irq_src[1] = 1'b0;
        pulse_eoi();
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL prio_rearb_latency got %0d want 1", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL prio_second_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL prio_second_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        irq_src[5] = 1'b0;
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_masking();
        cfg_write(CFG_ENABLE, 8'h00);
        cfg_write(CFG_EDGE, 8'h08);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        tick(); tick();
        n_checks++; if (pending[3] !== 1'b1) $display("FAIL mask_pending got %b want 1", pending[3]); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL mask_blocked got %b want 0", EX_irq); else n_pass++;
        sb.push_back('{id: 4'd3, vec: 32'h24});
        cfg_write(CFG_ENABLE, 8'h08);
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL mask_unmask_latency got %0d want 1", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL mask_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL mask_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_simultaneous();
        cfg_write(CFG_ENABLE, 8'hFF);
        cfg_write(CFG_EDGE, 8'h84);
        irq_src[2] = 1'b1;
        sb.push_back('{id: 4'd2, vec: 32'h20});
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 2) $display("FAIL sim_latency got %0d want 2", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL sim_first_id got %0d want %0d", irq_id, e.id); else n_pass++;
        irq_src[2] = 1'b0;
        tick();
        // New edge lands on the same edge as the ack that clears it.
        irq_src[2] = 1'b1;
        irq_ack = 1'b1;
        sb.push_back('{id: 4'd2, vec: 32'h20});
        tick();
        irq_ack = 1'b0;
        irq_src[2] = 1'b0;
        n_checks++; if (pending[2] !== 1'b1) $display("FAIL sim_set_wins got %b want 1", pending[2]); else n_pass++;
        n_checks++; if (in_service !== 1'b1) $display("FAIL sim_in_service got %b want 1", in_service); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL sim_ex_in_service got %b want 0", EX_irq); else n_pass++;
        // Ack outside REQ is ignored.
        pulse_ack();
        n_checks++; if (in_service !== 1'b1) $display("FAIL sim_stray_ack got %b want 1", in_service); else n_pass++;
        pulse_eoi();
        wait_irq(4, cyc);
        n_checks++; if (cyc !== 1) $display("FAIL sim_rereq_latency got %0d want 1", cyc); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL sim_rereq_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL sim_rereq_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        // ack and eoi together in REQ: only the ack takes effect.
        irq_ack = 1'b1; irq_eoi = 1'b1;
        tick();
        irq_ack = 1'b0; irq_eoi = 1'b0;
        n_checks++; if (in_service !== 1'b1) $display("FAIL sim_ack_eoi_service got %b want 1", in_service); else n_pass++;
        tick();
        n_checks++; if (in_service !== 1'b1) $display("FAIL sim_ack_eoi_hold got %b want 1", in_service); else n_pass++;
        n_checks++; if (pending[2] !== 1'b0) $display("FAIL sim_ack_clear got %b want 0", pending[2]); else n_pass++;
        pulse_eoi();
        // Software set of an edge-mode source.
        sb.push_back('{id: 4'd7, vec: 32'h34});
        cfg_write(CFG_SWSET, 8'h80);
        n_checks++; if (pending[7] !== 1'b1) $display("FAIL swset_pending got %b want 1", pending[7]); else n_pass++;
        wait_irq(4, cyc);
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL swset_id got %0d want %0d", irq_id, e.id); else n_pass++;
        n_checks++; if (INT_Vector !== e.vec) $display("FAIL swset_vector got %h want %h", INT_Vector, e.vec); else n_pass++;
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_reset_in_service();
        cfg_write(CFG_EDGE, 8'h00);
        irq_src[4] = 1'b1;
        sb.push_back('{id: 4'd4, vec: 32'h28});
        wait_irq(4, cyc);
        e = sb.pop_front();
        n_checks++; if (irq_id !== e.id) $display("FAIL rst_setup_id got %0d want %0d", irq_id, e.id); else n_pass++;
        pulse_ack();
        irq_src[4] = 1'b0;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        n_checks++; if (in_service !== 1'b0) $display("FAIL rst_in_service got %b want 0", in_service); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL rst_ex_irq got %b want 0", EX_irq); else n_pass++;
        n_checks++; if (irq_id !== 4'd0) $display("FAIL rst_irq_id got %0d want 0", irq_id); else n_pass++;
        n_checks++; if (INT_Vector !== 32'h18) $display("FAIL rst_vector got %h want 00000018", INT_Vector); else n_pass++;
        n_checks++; if (pending !== 8'h00) $display("FAIL rst_pending got %h want 00", pending); else n_pass++;
        // Enable mask must be cleared: a live level source stays blocked.
        irq_src[1] = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (pending[1] !== 1'b1) $display("FAIL rst_level_pending got %b want 1", pending[1]); else n_pass++;
        n_checks++; if (EX_irq !== 1'b0) $display("FAIL rst_enable_cleared got %b want 0", EX_irq); else n_pass++;
        irq_src[1] = 1'b0;
        tick();
    endtask

    initial begin
        Rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = '0;
        irq_ack = 1'b0; irq_eoi = 1'b0;
        test_reset();
        test_edge_basic();
        test_priority();
        test_masking();
        test_simultaneous();
        test_reset_in_service();
        n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_empty got %0d want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
